mesh_src_fifo: RTL and testbench

MESH_SRC_FIFO -- requirements
Module: mesh_src_fifo

---
 rtl/mesh_src_fifo.sv | 106 ++++++++++
 tb/tb_mesh_src_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mesh_src_fifo.sv
// mesh_src_fifo: terminal-to-mesh source FIFO with first-word fall-through.
//
// The terminal pushes packets; the mesh router pops them. The head packet is
// always visible on data_out_i_in while the FIFO is non-empty. Dropped pushes
// (full, no pop) and ignored pops (empty) are counted in saturating counters.
//
// Ports:
//   clk            in   clock, rising-edge active
//   reset          in   asynchronous active-low reset
//   push           in   terminal write request
//   data_in        in   packet to write [PCKG_SZ]
//   pop            in   mesh read request
//   data_out_i_in  out  head packet, zero when empty [PCKG_SZ]
//   pndng_i_in     out  FIFO non-empty
//   full           out  count == DEPTH
//   count          out  occupancy 0..DEPTH [$clog2(DEPTH+1)]
//   ovf_cnt        out  dropped-push counter, saturating [16]
//   udf_cnt        out  ignored-pop counter, saturating [16]
module mesh_src_fifo #(
    parameter int unsigned PCKG_SZ = 40,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [PCKG_SZ-1:0]           data_in,
    input  logic                         pop,
    output logic [PCKG_SZ-1:0]           data_out_i_in,
    output logic                         pndng_i_in,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  ovf_cnt,
    output logic [15:0]                  udf_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [PCKG_SZ-1:0] mem [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     ovf_q, ovf_d;
    logic [15:0]     udf_q, udf_d;

    logic is_full;
    logic is_empty;
    logic push_ok;
    logic pop_ok;

    assign is_full  = (count_q == FullCnt);
    assign is_empty = (count_q == '0);

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_ok = push && (!is_full || pop);
    assign pop_ok  = pop && !is_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);

        if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CntW'(1);

        if (push && !push_ok && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
        if (pop && !pop_ok && (udf_q != 16'hFFFF))   udf_d = udf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; the empty mask on the output hides stale entries.
    always_ff @(posedge clk) begin
        if (reset && push_ok) mem[wr_ptr_q] <= data_in;
    end

    assign data_out_i_in = is_empty ? '0 : mem[rd_ptr_q];
    assign pndng_i_in    = !is_empty;
    assign full          = is_full;
    assign count         = count_q;
    assign ovf_cnt       = ovf_q;
    assign udf_cnt       = udf_q;

endmodule

// File: tb/tb_mesh_src_fifo.sv
module tb_mesh_src_fifo;

    localparam int unsigned PCKG_SZ = 40;
    localparam int unsigned DEPTH   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               push;
    logic [PCKG_SZ-1:0] data_in;
    logic               pop;
    logic [PCKG_SZ-1:0] data_out_i_in;
    logic               pndng_i_in;
    logic               full;
    logic [4:0]         count;
    logic [15:0]        ovf_cnt;
    logic [15:0]        udf_cnt;

    int checks = 0;
    int errors = 0;

    mesh_src_fifo #(
        .PCKG_SZ (PCKG_SZ),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .full          (full),
        .count         (count),
        .ovf_cnt       (ovf_cnt),
        .udf_cnt       (udf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a packet queue plus two saturating drop counters.
    logic [PCKG_SZ-1:0] mq[$];
    int m_ovf = 0;
    int m_udf = 0;
    bit m_push_ok, m_pop_ok;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            m_pop_ok  = pop && (mq.size() > 0);
            m_push_ok = push && ((mq.size() < DEPTH) || pop);
            if (push && !m_push_ok && m_ovf < 65535) m_ovf++;
            if (pop && !m_pop_ok && m_udf < 65535) m_udf++;
            if (m_pop_ok) void'(mq.pop_front());
            if (m_push_ok) mq.push_back(data_in);
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        logic [PCKG_SZ-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_pndng", 64'(pndng_i_in), 64'(mq.size() > 0));
        chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
        chk("m_data", 64'(data_out_i_in), 64'(exp_data));
        chk("m_ovf", 64'(ovf_cnt), 64'(m_ovf));
        chk("m_udf", 64'(udf_cnt), 64'(m_udf));
    end

    // One clock with the given inputs; returns 1 time unit after the edge, inputs idle.
    task automatic step(input logic p, input logic q, input logic [PCKG_SZ-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
    endtask

    // Reset pulse between clock edges.
    task automatic pulse_reset();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pndng", 64'(pndng_i_in), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_data", 64'(data_out_i_in), 64'd0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [PCKG_SZ-1:0] exp_pkt;
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;

        // Reset held; push/pop must be ignored.
        repeat (2) step(1'b1, 1'b1, 40'hDEAD);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_pndng", 64'(pndng_i_in), 64'd0);
        chk("reset_ovf", 64'(ovf_cnt), 64'd0);
        chk("reset_udf", 64'(udf_cnt), 64'd0);
        reset = 1'b1;

        // Single push then pop.
        step(1'b1, 1'b0, 40'hA1);
        chk("a1_pndng", 64'(pndng_i_in), 64'd1);
        chk("a1_data", 64'(data_out_i_in), 64'hA1);
        step(1'b0, 1'b1, '0);
        chk("a1_pop_pndng", 64'(pndng_i_in), 64'd0);
        chk("a1_pop_data", 64'(data_out_i_in), 64'd0);

        // Fill, overflow by one, drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 40'(64'h10_0000_0000 + i));
        step(1'b1, 1'b0, 40'h11_1111_1111);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_ovf", 64'(ovf_cnt), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            exp_pkt = 40'(64'h10_0000_0000 + i);
            chk("drain_data", 64'(data_out_i_in), 64'(exp_pkt));
            step(1'b0, 1'b1, '0);
        end
        chk("drain_count", 64'(count), 64'd0);

        // Full FIFO, simultaneous push/pop across pointer wraps.
        pulse_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 40'(32'hC000 + i));
        for (int i = 0; i < 40; i++) begin
            exp_pkt = 40'(32'hC000 + i);
            chk("wrap_data", 64'(data_out_i_in), 64'(exp_pkt));
            step(1'b1, 1'b1, 40'(32'hC000 + 16 + i));
            chk("wrap_full", 64'(full), 64'd1);
        end
        chk("wrap_count", 64'(count), 64'd16);
        chk("wrap_ovf", 64'(ovf_cnt), 64'd0);

        // Underflow, then push+pop on empty.
        pulse_reset();
        repeat (3) step(1'b0, 1'b1, '0);
        chk("udf3", 64'(udf_cnt), 64'd3);
        chk("udf3_count", 64'(count), 64'd0);
        step(1'b1, 1'b1, 40'h77);
        chk("udf4", 64'(udf_cnt), 64'd4);
        chk("udf4_count", 64'(count), 64'd1);
        chk("udf4_data", 64'(data_out_i_in), 64'h77);

        // Mid-operation reset discards queued packets.
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 40'(32'h500 + i));
        chk("load5_count", 64'(count), 64'd5);
        pulse_reset();
        step(1'b1, 1'b0, 40'hB);
        chk("after_rst_data", 64'(data_out_i_in), 64'hB);
        chk("after_rst_count", 64'(count), 64'd1);

        // Overflow counter saturation.
        pulse_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 40'(i));
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 40'hFF);
        chk("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
        chk("ovf_sat_count", 64'(count), 64'd16);
        chk("ovf_sat_head", 64'(data_out_i_in), 64'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
